test_bed: RTL and testbench

Self-checking answer monitor for processor-level simulation. It snoops the D-cache write port of the CHIP top level (word address, write data, write enable) and compares every write into the answer region against a golden table. It counts mismatches and missing answers, and measures execution duration in cycles. It raises `finish` once the program writes the end marker. It sits beside CHIP and the two slow_memory models in the top-level bench and is simulation-only (`$readmemh` golden load is permitted).

---
 rtl/test_bed.sv | 108 ++++++++++
 tb/tb_test_bed.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/test_bed.sv
// test_bed: D-cache write snooper that checks answers against a golden table.
// Optional console reporting is enabled by defining TESTBED_DISPLAY_EN.
module test_bed #(
  parameter logic [29:0] ANS_BASE    = 30'd64,
  parameter int          ANS_NUM     = 16,
  parameter logic [29:0] END_ADDR    = 30'd255,
  parameter logic [31:0] END_DATA    = 32'h0000_0FFF,
  parameter string       GOLDEN_FILE = "golden.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  output logic [7:0]  error_num,
  output logic [15:0] duration,
  output logic        finish
);

  localparam int IW = (ANS_NUM > 1) ? $clog2(ANS_NUM) : 1;
  localparam logic [30:0] ANS_END = {1'b0, ANS_BASE} + 31'(ANS_NUM);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_CHECK  = 2'd1,
    S_REPORT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               curstate_q;
  logic [ANS_NUM-1:0]   checked_q;
  logic [7:0]           err_q;
  logic [15:0]          dur_q;
  logic                 fin_q;

  logic [31:0] golden [ANS_NUM];

  logic          ans_hit;
  logic          end_hit;
  logic [IW-1:0] idx;
  logic          mism;
  logic [7:0]    err_inc;
  logic [8:0]    miss_cnt;
  logic [9:0]    tot;
  logic [7:0]    err_fin;

  assign ans_hit = wen
                && ({1'b0, addr} >= {1'b0, ANS_BASE})
                && ({1'b0, addr} < ANS_END);
  assign end_hit = wen && (addr == END_ADDR) && (data == END_DATA);
  assign idx     = IW'(addr - ANS_BASE);
  assign mism    = ans_hit && (data != golden[idx]);
  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < ANS_NUM; i++) begin
      miss_cnt = miss_cnt + 9'(!checked_q[i]);
    end
    tot     = {2'b00, err_q} + {1'b0, miss_cnt};
    err_fin = (tot > 10'd255) ? 8'hFF : tot[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curstate_q <= S_WAIT;
      checked_q  <= '0;
      err_q      <= '0;
      dur_q      <= '0;
      fin_q      <= 1'b0;
    end else begin
      unique case (curstate_q)
        S_WAIT, S_CHECK: begin
          if (dur_q != 16'hFFFF) dur_q <= dur_q + 16'd1;
          if (ans_hit) begin
            checked_q[idx] <= 1'b1;
            if (mism) begin
              err_q <= err_inc;
`ifdef TESTBED_DISPLAY_EN
              $display("test_bed: mismatch index=%0d got=%08h exp=%08h",
                       idx, data, golden[idx]);
`endif
            end
            if (curstate_q == S_WAIT) curstate_q <= S_CHECK;
          end
          if (curstate_q == S_CHECK && end_hit) curstate_q <= S_REPORT;
        end
        S_REPORT: begin
          err_q      <= err_fin;
          fin_q      <= 1'b1;
          curstate_q <= S_DONE;
`ifdef TESTBED_DISPLAY_EN
          $display("test_bed: error_num=%0d duration=%0d %s",
                   err_fin, dur_q, (err_fin == 8'd0) ? "PASS" : "FAIL");
`endif
        end
        S_DONE: begin
          fin_q <= 1'b1;
        end
      endcase
    end
  end

  assign error_num = err_q;
  assign duration  = dur_q;
  assign finish    = fin_q;

endmodule

// File: tb/tb_test_bed.sv
// tb_test_bed: directed checks of the answer monitor.
// Golden table is preloaded with i*3 through the design hierarchy.
module tb_test_bed;

  logic        clk;
  logic        rst;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic [7:0]  error_num;
  logic [15:0] duration;
  logic        finish;

  int checks;
  int failures;

  test_bed #(
    .ANS_BASE   (30'd64),
    .ANS_NUM    (16),
    .END_ADDR   (30'd255),
    .END_DATA   (32'h0000_0FFF),
    .GOLDEN_FILE("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .wen      (wen),
    .error_num(error_num),
    .duration (duration),
    .finish   (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    addr = a;
    data = d;
    wen  = 1'b1;
    @(posedge clk);
    #1;
    wen  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic all_good();
    for (int i = 0; i < 16; i++) wr(30'(64 + i), 32'(i * 3));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b0;
    wen  = 1'b0;
    addr = '0;
    data = '0;
    for (int i = 0; i < 16; i++) dut.golden[i] = 32'(i * 3);
    @(posedge clk);
    #1;
    chk("rst_err", 32'(error_num), 32'd0);
    chk("rst_dur", 32'(duration), 32'd0);
    chk("rst_fin", 32'(finish), 32'd0);
    chk("rst_st", 32'(dut.curstate_q), 32'd0);
    rst = 1'b1;

    // all correct answers
    all_good();
    chk("t1_st_chk", 32'(dut.curstate_q), 32'd1);
    wr(30'd255, 32'h0FFF);
    chk("t1_st_rep", 32'(dut.curstate_q), 32'd2);
    chk("t1_fin_n", 32'(finish), 32'd0);
    chk("t1_dur_n", 32'(duration), 32'd17);
    idle(1);
    chk("t1_fin", 32'(finish), 32'd1);
    chk("t1_err", 32'(error_num), 32'd0);
    idle(5);
    chk("t1_dur_frz", 32'(duration), 32'd17);
    chk("t1_st_done", 32'(dut.curstate_q), 32'd3);

    // mismatches at indices 2 and 7
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 2 || i == 7) wr(30'(64 + i), 32'(i * 3) ^ 32'h1);
      else wr(30'(64 + i), 32'(i * 3));
      if (i == 2) chk("t2_err_lat", 32'(error_num), 32'd1);
    end
    chk("t2_err_pre", 32'(error_num), 32'd2);
    wr(30'd255, 32'h0FFF);
    idle(1);
    chk("t2_err", 32'(error_num), 32'd2);
    chk("t2_fin", 32'(finish), 32'd1);

    // missing and repeated answers, writes in REPORT and DONE ignored
    do_reset();
    for (int i = 0; i < 10; i++) wr(30'(64 + i), 32'(i * 3));
    wr(30'd67, 32'hDEAD);
    chk("t3_err_rep", 32'(error_num), 32'd1);
    wr(30'd255, 32'h0FFF);
    chk("t3_err_n", 32'(error_num), 32'd1);
    wr(30'd64, 32'hBAD);
    chk("t3_err", 32'(error_num), 32'd7);
    chk("t3_fin", 32'(finish), 32'd1);
    wr(30'd65, 32'hBAD);
    chk("t3_err_done", 32'(error_num), 32'd7);

    // guarded end marker and region boundaries
    do_reset();
    wr(30'd255, 32'h0FFF);
    chk("t4_st_wait", 32'(dut.curstate_q), 32'd0);
    idle(3);
    chk("t4_fin_wait", 32'(finish), 32'd0);
    wr(30'd63, 32'h5);
    chk("t4_st_below", 32'(dut.curstate_q), 32'd0);
    wr(30'd64, 32'd0);
    chk("t4_st_chk", 32'(dut.curstate_q), 32'd1);
    wr(30'd255, 32'h1234);
    wr(30'd80, 32'h7);
    wr(30'd79, 32'd45);
    idle(2);
    chk("t4_st_bad_end", 32'(dut.curstate_q), 32'd1);
    chk("t4_fin_bad_end", 32'(finish), 32'd0);
    chk("t4_err_pre", 32'(error_num), 32'd0);
    wr(30'd255, 32'h0FFF);
    idle(1);
    chk("t4_err_miss", 32'(error_num), 32'd14);
    chk("t4_fin", 32'(finish), 32'd1);

    // error saturation including the missing-answer tally
    do_reset();
    for (int i = 0; i < 254; i++) wr(30'd64, 32'h1);
    chk("t5_err_fe", 32'(error_num), 32'hFE);
    for (int i = 0; i < 46; i++) wr(30'd64, 32'h1);
    chk("t5_err_ff", 32'(error_num), 32'hFF);
    wr(30'd255, 32'h0FFF);
    idle(1);
    chk("t5_err_rep", 32'(error_num), 32'hFF);

    // duration saturation
    do_reset();
    idle(65534);
    chk("t5_dur_fffe", 32'(duration), 32'hFFFE);
    idle(1);
    chk("t5_dur_ffff", 32'(duration), 32'hFFFF);
    idle(4465);
    chk("t5_dur_sat", 32'(duration), 32'hFFFF);

    // asynchronous reset mid-run, then a clean run
    do_reset();
    wr(30'd64, 32'h9);
    wr(30'd65, 32'h9);
    wr(30'd66, 32'h9);
    chk("t6_err3", 32'(error_num), 32'd3);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_err0", 32'(error_num), 32'd0);
    chk("t6_dur0", 32'(duration), 32'd0);
    chk("t6_fin0", 32'(finish), 32'd0);
    chk("t6_st0", 32'(dut.curstate_q), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_dur_wait", 32'(duration), 32'd1);
    do_reset();
    all_good();
    wr(30'd255, 32'h0FFF);
    idle(1);
    chk("t6_err", 32'(error_num), 32'd0);
    chk("t6_fin", 32'(finish), 32'd1);
    chk("t6_dur", 32'(duration), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
